ex_muldiv: RTL
==============

Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the Execute stage.
- Consumes the operands, funct3 and destination register that the ID/EX stage register presents, alongside the single-cycle ALU.
- Holds the pipeline through its stall output while it computes.
- Returns a 32-bit result with a one-cycle done strobe, which the Execute-stage result mux uses in place of the ALU result.

Parameters:
XLEN, 32, operand/result width; iteration count = XLEN
CNTW, 6, iteration counter width; must satisfy 2^CNTW > XLEN

Ports:
clk       input   1     clock, rising edge
reset     input   1     asynchronous, active-low reset; reset=0 clears all state immediately
start     input   1     M-extension instruction valid in EX (decoded MulDivE)
funct3    input   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
srcA      input   XLEN  forwarded rs1 value
srcB      input   XLEN  forwarded rs2 value
RdE       input   5     destination register of the EX instruction
FlushE    input   1     kill the EX instruction (branch/jump taken)
stall     output  1     to hazard unit: hold F/D/E stages, bubble M
done      output  1     one-cycle strobe; result and RdOut valid
result    output  XLEN  final result
RdOut     output  5     destination register of the completed op

Behaviour:
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- Reset values: result=0, done=0, RdOut=0, count=0, all internal registers 0. stall is forced 0 while reset=0.
- IDLE:
  - start=1 and FlushE=0: latch funct3 and RdE; latch |srcA| and |srcB| per signedness; latch result-sign flags; latch raw operands for special cases; count=0; go to CALC.
  - Signedness: MUL/MULH/DIV/REM treat both operands as signed. MULHSU: srcA signed, srcB unsigned. MULHU/DIVU/REMU: both unsigned. MUL's low word is sign-independent.
- CALC: one iteration per cycle, count increments.
  - Multiply: shift-add into a 2*XLEN product.
  - Divide: restoring shift-subtract, producing quotient and remainder.
  - When count=XLEN-1, go to DONE.
- DONE:
  - done=1; result and RdOut registered valid; stall=0 so the pipeline advances this cycle.
  - start is ignored in DONE: it is the same instruction leaving EX.
  - Next state is always IDLE.
- Latency is fixed regardless of operands. start first seen at cycle 0, CALC covers cycles 1..32, done=1 at cycle 33. stall is high in cycles 0..32 (33 cycles).
- stall = (state==IDLE & start & ~FlushE) | (state==CALC). The IDLE term is combinational from start.
- Result selection:
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32], where product is negated (two's complement, 64-bit) if the sign flag is set.
  - DIV/DIVU: quotient, negated if operand signs differ (signed ops only).
  - REM/REMU: remainder, taking the sign of the dividend (signed ops only).
- Special cases, which override the iterative result in DONE:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give srcA.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- FlushE=1 in any state: next state IDLE, done stays 0, no result is produced.
  - Same-cycle start and FlushE: op is not accepted and stall=0.
  - FlushE in DONE still suppresses nothing already registered. done is already high that cycle; the hazard unit must squash the writeback.
- Back-to-back ops: a new start is accepted in the IDLE cycle immediately after DONE.
- Reset asserted mid-operation: immediate return to IDLE with outputs zeroed; the in-flight op is lost.
- result and RdOut hold their value after done until the next DONE or reset.

Test Plan:
- MUL, srcA=7, srcB=0xFFFFFFFD, RdE=5 -> stall high cycles 0..32; cycle 33: done=1, result=0xFFFFFFEB, RdOut=5; done=0 at cycle 34.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 9/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Start MUL, assert FlushE at cycle 10 -> stall=0 from cycle 11, no done pulse. New DIV started at cycle 12 -> done at cycle 45.
- Drive reset=0 at cycle 5 of a DIV -> stall/done/result/RdOut go 0 immediately without waiting for a clock edge. Release reset, then two back-to-back MULs -> two done pulses exactly 34 cycles apart.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the Execute stage.
// Operands are captured on start, reduced to magnitudes, and processed one bit
// per cycle. Multiplies use shift-add and divides use restoring shift-subtract.
// Both share one double-width accumulator. The result is sign-corrected and
// registered on the last iteration, and done pulses for one cycle after that.
//
//   state | meaning
//   IDLE  | waiting for an M instruction in EX
//   CALC  | one iteration per cycle, XLEN cycles
//   DONE  | result/RdOut valid, done high, pipeline released
module ex_muldiv #(
  parameter int XLEN = 32,
  parameter int CNTW = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic [4:0]      RdE,
  input  logic            FlushE,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      RdOut
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   a_abs_q, b_abs_q, a_raw_q, b_raw_q;
  logic              neg_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CNTW-1:0]   count_q;

  logic              accept, last_iter, finish;
  logic              a_signed_in, b_signed_in, a_neg_in, b_neg_in, neg_in;
  logic [XLEN-1:0]   a_abs_in, b_abs_in;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     div_trial, div_diff;
  logic [2*XLEN-1:0] div_nxt, acc_nxt, prod_fin;
  logic [XLEN-1:0]   quo, rem, res_fin;
  logic              div_zero, div_ovf;

  assign accept    = (state == IDLE) && start && !FlushE;
  assign last_iter = (count_q == CNTW'(XLEN-1));
  assign finish    = (state == CALC) && last_iter && !FlushE;

  // Stall holds F/D/E from the accepting cycle through the final iteration;
  // it is gated by reset so nothing is held while the unit is in reset.
  assign stall = reset && (accept || (state == CALC));

  // MUL's low word is the same either way, so it is treated as signed.
  always_comb begin
    a_signed_in = 1'b0;
    b_signed_in = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin a_signed_in = 1'b1; b_signed_in = 1'b1; end
      3'b010:                         begin a_signed_in = 1'b1; b_signed_in = 1'b0; end
      default:                        begin a_signed_in = 1'b0; b_signed_in = 1'b0; end
    endcase
  end

  // Remainders follow the dividend sign; everything else uses the XOR of the operand signs.
  assign a_neg_in = a_signed_in && srcA[XLEN-1];
  assign b_neg_in = b_signed_in && srcB[XLEN-1];
  assign a_abs_in = a_neg_in ? (~srcA + 1'b1) : srcA;
  assign b_abs_in = b_neg_in ? (~srcB + 1'b1) : srcB;
  assign neg_in   = (funct3[2] && funct3[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);

  // One iteration step. For a multiply the accumulator starts as {0, b}.
  // For a divide it starts as {0, a}: the upper half is the partial remainder
  // and the lower half shifts the quotient in.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_abs_q} : '0);
    mul_nxt   = {mul_sum, acc_q[XLEN-1:1]};
    div_trial = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_trial - {1'b0, b_abs_q};
    if (!div_diff[XLEN])
      div_nxt = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      div_nxt = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    acc_nxt = op_q[2] ? div_nxt : mul_nxt;
  end

  // Final result from the last step's accumulator, with the sign correction
  // applied and the divide special cases taking priority.
  always_comb begin
    prod_fin = neg_q ? (~acc_nxt + 1'b1) : acc_nxt;
    quo      = acc_nxt[XLEN-1:0];
    rem      = acc_nxt[2*XLEN-1:XLEN];
    div_zero = (b_raw_q == '0);
    div_ovf  = !op_q[0] && (a_raw_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_raw_q == '1);
    res_fin  = '0;
    case (op_q)
      3'b000:                 res_fin = prod_fin[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_fin = prod_fin[2*XLEN-1:XLEN];
      3'b100, 3'b101: begin
        if (div_zero)     res_fin = '1;
        else if (div_ovf) res_fin = {1'b1, {(XLEN-1){1'b0}}};
        else              res_fin = neg_q ? (~quo + 1'b1) : quo;
      end
      default: begin
        if (div_zero)     res_fin = a_raw_q;
        else if (div_ovf) res_fin = '0;
        else              res_fin = neg_q ? (~rem + 1'b1) : rem;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. A flush always wins, and DONE always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC: begin
        if (FlushE)         state_nxt = IDLE;
        else if (last_iter) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= '0;
      rd_q    <= '0;
      a_abs_q <= '0;
      b_abs_q <= '0;
      a_raw_q <= '0;
      b_raw_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      count_q <= '0;
      done    <= 1'b0;
      result  <= '0;
      RdOut   <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_q    <= funct3;
        rd_q    <= RdE;
        a_abs_q <= a_abs_in;
        b_abs_q <= b_abs_in;
        a_raw_q <= srcA;
        b_raw_q <= srcB;
        neg_q   <= neg_in;
        acc_q   <= funct3[2] ? {{XLEN{1'b0}}, a_abs_in} : {{XLEN{1'b0}}, b_abs_in};
        count_q <= '0;
      end else if (state == CALC) begin
        acc_q   <= acc_nxt;
        count_q <= count_q + 1'b1;
      end
      if (finish) begin
        done   <= 1'b1;
        result <= res_fin;
        RdOut  <= rd_q;
      end
    end
  end

endmodule
